// File: rtl/wrr_arbiter_if.sv
// Purpose : handshake/grant bundle between the requesters, the weighted round-robin arbiter and the shared resource.
// Latency : no logic; wires only.
// Backpres: ready_i from the resource stalls the current grant; the signal names take the arbiter's point of view.
// Ports   : req_i/weight_i/ready_i flow into the arbiter; gnt_o/gnt_idx_o/gnt_valid_o/credit_o flow out of it.
interface wrr_arbiter_if #(
   parameter int NUM_PORTS = 4,
   parameter int WEIGHT_W  = 4,
   parameter int IDX_W     = $clog2(NUM_PORTS)
);
   logic [NUM_PORTS-1:0]          req_i;        // per-port request, level-sensitive
   logic [NUM_PORTS*WEIGHT_W-1:0] weight_i;     // port p weight at [p*WEIGHT_W +: WEIGHT_W]
   logic                          ready_i;      // resource accepts the current grant
   logic [NUM_PORTS-1:0]          gnt_o;        // one-hot grant, or zero
   logic [IDX_W-1:0]              gnt_idx_o;    // binary index of the granted port
   logic                          gnt_valid_o;  // a grant is on the bus
   logic [WEIGHT_W-1:0]           credit_o;     // transfers left in the burst, including the current one

   // Arbiter side.
   modport master (
      input  req_i, weight_i, ready_i,
      output gnt_o, gnt_idx_o, gnt_valid_o, credit_o
   );

   // Requester / resource side.
   modport slave (
      output req_i, weight_i, ready_i,
      input  gnt_o, gnt_idx_o, gnt_valid_o, credit_o
   );
endinterface

// File: rtl/wrr_arbiter.sv
// Purpose : weighted round-robin arbiter; each port keeps the grant for up to max(weight,1) accepted transfers.
// Latency : one cycle from req_i to gnt_o; back-to-back grants (no idle bubble) on burst end or handover.
// Backpres: while ready_i is low the grant and credit are held indefinitely, unless the granted port withdraws.
// Ports   : clk, reset (async, active-high) and bus (wrr_arbiter_if.master) carrying requests, weights,
//           ready, and the registered grant/index/valid/credit outputs.
module wrr_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int WEIGHT_W  = 4,
   parameter int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic          clk,
   input  logic          reset,
   wrr_arbiter_if.master bus
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     cur_q, cur_d;        // granted port (0 when idle)
   logic [IDX_W-1:0]     ptr_q, ptr_d;        // rotation pointer: where the next idle search starts
   logic [WEIGHT_W-1:0]  credit_q, credit_d;  // transfers remaining in the burst
   logic [NUM_PORTS-1:0] gnt_q, gnt_d;        // one-hot grant kept in a flop so gnt_o is glitch-free

   // Unpacked view of the weight bus.
   logic [WEIGHT_W-1:0]  weight_a [NUM_PORTS];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_weight
      assign weight_a[p] = bus.weight_i[p*WEIGHT_W +: WEIGHT_W];
   end

   // Port following the current one, with wrap for any NUM_PORTS.
   logic [IDX_W-1:0] cur_inc;
   assign cur_inc = (cur_q == IDX_W'(NUM_PORTS - 1)) ? '0 : cur_q + IDX_W'(1);

   // From idle the search starts at ptr; when a burst ends or is abandoned the pointer moves to
   // cur+1 in the same cycle, so the search already starts there. Because the search wraps all the
   // way round, a lone requester that is the current port wins again.
   logic [IDX_W-1:0] search_start;
   assign search_start = (state_q == ST_GRANT) ? cur_inc : ptr_q;

   // ------------------------------------------------------------------
   // Rotating priority search: first requesting port at or after search_start.
   // ------------------------------------------------------------------
   logic             win_vld;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W:0]   srch_sum;   // one extra bit so start+offset cannot overflow before the wrap
   logic [IDX_W-1:0] srch_cand;

   always_comb begin
      win_vld   = 1'b0;
      win_idx   = '0;
      srch_sum  = '0;
      srch_cand = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         srch_sum = {1'b0, search_start} + (IDX_W + 1)'(i);
         if (srch_sum >= (IDX_W + 1)'(NUM_PORTS)) begin
            srch_sum = srch_sum - (IDX_W + 1)'(NUM_PORTS);
         end
         srch_cand = srch_sum[IDX_W-1:0];
         if (!win_vld && bus.req_i[srch_cand]) begin
            win_vld = 1'b1;
            win_idx = srch_cand;
         end
      end
   end

   // Weight is sampled only here, at credit-load time; zero weight still earns one transfer.
   logic [WEIGHT_W-1:0] win_credit;
   assign win_credit = (weight_a[win_idx] == '0) ? WEIGHT_W'(1) : weight_a[win_idx];

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cur_q    <= '0;
         ptr_q    <= '0;
         credit_q <= '0;
         gnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
         gnt_q    <= gnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   logic cur_req;      // granted port is still asking
   logic rearb;        // take the search result (or fall back to idle)

   assign cur_req = bus.req_i[cur_q];

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      ptr_d    = ptr_q;
      credit_d = credit_q;
      gnt_d    = gnt_q;
      rearb    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            rearb = 1'b1;
         end
         ST_GRANT: begin
            // In GRANT the valid output is high, so ready_i alone marks an accepted transfer.
            if (bus.ready_i && cur_req && (credit_q > WEIGHT_W'(1))) begin
               credit_d = credit_q - WEIGHT_W'(1);
            end else if (bus.ready_i || !cur_req) begin
               // Burst exhausted, or the port withdrew while stalled (no credit consumed).
               ptr_d = cur_inc;
               rearb = 1'b1;
            end
            // Otherwise stalled with the request still up: hold everything.
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (rearb) begin
         if (win_vld) begin
            state_d        = ST_GRANT;
            cur_d          = win_idx;
            credit_d       = win_credit;
            gnt_d          = '0;
            gnt_d[win_idx] = 1'b1;
         end else begin
            // Idle outputs read zero, not stale values.
            state_d  = ST_IDLE;
            cur_d    = '0;
            credit_d = '0;
            gnt_d    = '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs: flop values only, no path from req_i or ready_i.
   // ------------------------------------------------------------------
   always_comb begin
      bus.gnt_o       = gnt_q;
      bus.gnt_idx_o   = cur_q;
      bus.gnt_valid_o = (state_q == ST_GRANT);
      bus.credit_o    = credit_q;
   end

   // Structural invariants of the registered state.
   a_grant_onehot : assert property (@(posedge clk) disable iff (reset)
      (state_q == ST_GRANT) |-> ($onehot(gnt_q) && (credit_q != '0) && gnt_q[cur_q]));

   a_idle_zero : assert property (@(posedge clk) disable iff (reset)
      (state_q == ST_IDLE) |-> ((gnt_q == '0) && (cur_q == '0) && (credit_q == '0)));

endmodule

// File: tb/tb_wrr_arbiter.sv
// Purpose : directed self-checking bench for wrr_arbiter (4 ports, 4-bit weights).
// Latency : inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpres: ready_i is driven directly by the directed steps.
module tb_wrr_arbiter;

   localparam int NP = 4;
   localparam int WW = 4;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   wrr_arbiter_if #(.NUM_PORTS(NP), .WEIGHT_W(WW)) bus ();

   wrr_arbiter #(.NUM_PORTS(NP), .WEIGHT_W(WW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] idx,
                          input logic vld, input logic [3:0] cr);
      chk({tag, ".gnt"},    32'(bus.gnt_o),       32'(g));
      chk({tag, ".idx"},    32'(bus.gnt_idx_o),   32'(idx));
      chk({tag, ".valid"},  32'(bus.gnt_valid_o), 32'(vld));
      chk({tag, ".credit"}, 32'(bus.credit_o),    32'(cr));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq1_idx [6]  = '{0, 1, 2, 3, 0, 1};
      int seq2_idx [10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
      int seq2_cr  [10] = '{3, 2, 1, 1, 2, 1, 1, 3, 2, 1};

      // Reset state
      reset        = 1'b1;
      bus.req_i    = '0;
      bus.weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
      bus.ready_i  = 1'b0;
      tick();
      tick();
      chk_all("reset", 4'b0000, 2'd0, 1'b0, 4'd0);
      reset = 1'b0;

      // 1: all weights 1, everyone requesting, ready high
      bus.req_i   = 4'b1111;
      bus.ready_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("t1.idx%0d", k), 32'(bus.gnt_idx_o), 32'(seq1_idx[k]));
         chk($sformatf("t1.valid%0d", k), 32'(bus.gnt_valid_o), 32'd1);
      end

      // 2: weights w0=3 w1=1 w2=2 w3=0
      do_reset();
      bus.weight_i = {4'd0, 4'd2, 4'd1, 4'd3};
      bus.req_i    = 4'b1111;
      bus.ready_i  = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk($sformatf("t2.idx%0d", k), 32'(bus.gnt_idx_o), 32'(seq2_idx[k]));
         chk($sformatf("t2.credit%0d", k), 32'(bus.credit_o), 32'(seq2_cr[k]));
      end

      // 3: lone requester on port 2, then it drops its request
      do_reset();
      bus.weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
      bus.req_i    = 4'b0100;
      bus.ready_i  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_all($sformatf("t3.hold%0d", k), 4'b0100, 2'd2, 1'b1, 4'd1);
      end
      bus.req_i = 4'b0000;
      tick();
      chk_all("t3.drop", 4'b0000, 2'd0, 1'b0, 4'd0);

      // 4: backpressure on port 1 (w1=2); the pointer left at 3 above must be cleared by reset
      do_reset();
      bus.weight_i = {4'd1, 4'd1, 4'd2, 4'd1};
      bus.req_i    = 4'b1010;
      bus.ready_i  = 1'b0;
      tick();
      chk_all("t4.first", 4'b0010, 2'd1, 1'b1, 4'd2);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("t4.stall_gnt%0d", k), 32'(bus.gnt_o), 32'h2);
         chk($sformatf("t4.stall_cr%0d", k), 32'(bus.credit_o), 32'd2);
      end
      bus.ready_i = 1'b1;
      tick();
      chk_all("t4.acc1", 4'b0010, 2'd1, 1'b1, 4'd1);
      tick();
      chk_all("t4.next", 4'b1000, 2'd3, 1'b1, 4'd1);

      // 5: withdrawal of port 0 while stalled hands over to port 3 with its own weight
      do_reset();
      bus.weight_i = {4'd3, 4'd1, 4'd1, 4'd2};
      bus.req_i    = 4'b1001;
      bus.ready_i  = 1'b0;
      tick();
      chk_all("t5.p0", 4'b0001, 2'd0, 1'b1, 4'd2);
      bus.req_i = 4'b1000;
      tick();
      chk_all("t5.p3", 4'b1000, 2'd3, 1'b1, 4'd3);

      // 6: reset mid-burst on port 3 (credit 2) is asynchronous
      bus.ready_i = 1'b1;
      tick();
      chk_all("t6.burst", 4'b1000, 2'd3, 1'b1, 4'd2);
      reset = 1'b1;
      #1;
      chk_all("t6.async", 4'b0000, 2'd0, 1'b0, 4'd0);
      tick();
      reset       = 1'b0;
      bus.req_i   = 4'b1010;
      bus.ready_i = 1'b0;
      tick();
      chk_all("t6.after", 4'b0010, 2'd1, 1'b1, 4'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wrr_arbiter.md
# wrr_arbiter

Weighted round-robin arbiter with a registered one-hot grant and a valid/ready handshake toward the shared resource. Each port gets a burst of up to `weight` consecutive accepted transfers before priority rotates to the next requesting port. It supersedes the plain round-robin arbiter in front of shared buses and memory ports, where one port needs proportionally more bandwidth and a grant must stay stable until the transfer is accepted.

## Interface
- `NUM_PORTS`, default 4: number of requesters; legal range is 2 or more.
- `WEIGHT_W`, default 4: width of each per-port weight field; maximum burst is 2^WEIGHT_W-1.
- `IDX_W`, default `$clog2(NUM_PORTS)`: width of the grant index; derived parameter, do not override.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_i` input NUM_PORTS: per-port request, level-sensitive.
- `weight_i` input NUM_PORTS*WEIGHT_W: port p weight at bits [p*WEIGHT_W +: WEIGHT_W]; quasi-static configuration.
- `ready_i` input 1: downstream accepts the current grant this cycle.
- `gnt_o` output NUM_PORTS: registered grant, one-hot or zero.
- `gnt_idx_o` output IDX_W: binary index of the granted port.
- `gnt_valid_o` output 1: high when `gnt_o` is non-zero.
- `credit_o` output WEIGHT_W: transfers remaining in the current burst, including the one on the bus.

## Operation
- There are two states.
  - IDLE: `gnt_valid_o`=0.
  - GRANT: `gnt_valid_o`=1 and exactly one bit of `gnt_o` is set.
- A transfer is accepted when `gnt_valid_o` & `ready_i`.
- Rotation pointer `ptr`: the search starts at index `ptr`, checks ptr, ptr+1, …, NUM_PORTS-1, then wraps from 0 to ptr-1. The winner is the first port p with `req_i[p]`=1.
- IDLE → GRANT: when any `req_i` bit is high, register the winner. Load `credit` with the winner's weight; a weight of 0 is loaded as 1.
- GRANT, accepted, `credit`>1 and `req_i[cur]`=1: stay on the current port with `credit`-1.
- GRANT, accepted, and either `credit`=1 or `req_i[cur]`=0: set `ptr`=cur+1 mod NUM_PORTS and re-arbitrate using the same-cycle `req_i`.
  - If there is a winner, move directly to it (no idle bubble) with a fresh credit load.
  - If a lone requester is the current port, it wins again and its credit is reloaded.
  - If there is no winner, go to IDLE.
- GRANT, not accepted, `req_i[cur]`=1: hold `gnt_o`, `gnt_idx_o` and `credit` unchanged, indefinitely.
- GRANT, not accepted, `req_i[cur]`=0 (request withdrawn): consume no credit, set `ptr`=cur+1, re-arbitrate as for exhaustion.
- `weight_i` is sampled only at credit-load time. Changing it mid-burst does not affect the current burst.
- `credit` arithmetic is unsigned WEIGHT_W bits; it never decrements below 1 while in GRANT.
- `gnt_idx_o` and `credit_o` are don't-care-free: both read 0 in IDLE.

## Timing
- Reset values: `gnt_o`=0, `gnt_idx_o`=0, `gnt_valid_o`=0, `credit_o`=0, `ptr`=0, state IDLE.
- Assertion of `reset` clears all state immediately, including mid-burst. The first grant after reset release searches from port 0.
- Latency: a request seen on edge t (arbiter idle) produces a grant visible after edge t. This is one cycle from `req_i` to `gnt_o`.
- Grant switch: an acceptance on edge t moves `gnt_o` to the next winner after edge t. A port with a request always asserted sees back-to-back service: one accepted transfer per cycle with `ready_i` held high.
- All outputs come straight from flops; there is no combinational path from `req_i` or `ready_i` to any output.
- Fairness bound: with all ports requesting and `ready_i`=1, port p waits at most sum over q≠p of max(w_q,1) cycles between bursts.

## Test plan
- NUM_PORTS=4, all weights 1, `req_i`=4'b1111, `ready_i`=1: `gnt_idx_o` sequence after reset is 0,1,2,3,0,1, one cycle each, `gnt_valid_o` continuously 1.
- Weights {w0=3,w1=1,w2=2,w3=0}, `req_i`=4'b1111, `ready_i`=1: index sequence 0,0,0,1,2,2,3,0,0,0. `credit_o` at the three port-0 slots reads 3,2,1.
- Only port 2 requesting with weight 1, `ready_i`=1: grant stays on index 2 every cycle, `credit_o`=1. Dropping `req_i` gives `gnt_valid_o`=0 after the next edge.
- Backpressure: grant on port 1 with weight 2 and `ready_i`=0 for 5 cycles: `gnt_o`=4'b0010 and `credit_o`=2 held for all 5 cycles. Then `ready_i`=1 for 2 cycles: grant moves to the next requester.
- Withdrawal: port 0 granted with `req_i`=4'b1001 and `ready_i`=0, then `req_i` becomes 4'b1000: next cycle `gnt_o`=4'b1000 and `credit_o`=w3.
- Assert `reset` mid-burst on port 3 with credit 2: outputs go to 0 asynchronously. After release with `req_i`=4'b1010, the first grant is port 1.
